// File: rtl/dma_frame_unpacker_if.sv
// Bus bundle for dma_frame_unpacker: buffer read port, record stream and status.
// master = environment side (buffer + record sink), slave = the unpacker.
interface dma_frame_unpacker_if;
    logic        en;
    logic [63:0] buf_r_data;
    logic        buf_r_empty;
    logic [3:0]  buf_r_data_width;
    logic        buf_r_ready;
    logic [63:0] rec_data;
    logic [15:0] rec_idx;
    logic        rec_last;
    logic        rec_valid;
    logic        rec_ready;
    logic        frame_done;
    logic        busy;

    modport master (
        output en, buf_r_data, buf_r_empty, rec_ready,
        input  buf_r_data_width, buf_r_ready, rec_data, rec_idx, rec_last, rec_valid,
        input  frame_done, busy
    );

    modport slave (
        input  en, buf_r_data, buf_r_empty, rec_ready,
        output buf_r_data_width, buf_r_ready, rec_data, rec_idx, rec_last, rec_valid,
        output frame_done, busy
    );
endinterface

// File: rtl/dma_frame_unpacker.sv
// Parses a little-endian byte stream from the DMA buffer into frames:
// a 16-bit record count followed by that many REC_BYTES-wide records.
// Records leave through a single-entry valid/ready output register.
module dma_frame_unpacker #(
    parameter int unsigned REC_BYTES = 4,
    // Reserved for simulation-only event logging; no effect on the hardware.
    parameter int unsigned DEBUG     = 1
) (
    input logic                 clk,
    input logic                 rst,
    dma_frame_unpacker_if.slave bus
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StHdr   = 3'd1;
    localparam logic [2:0] StRec   = 3'd2;
    localparam logic [2:0] StDrain = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    localparam logic [3:0]  RecWidth = 4'(REC_BYTES);
    localparam logic [63:0] RecMask  = (REC_BYTES >= 8) ? {64{1'b1}} :
                                       ((64'd1 << (REC_BYTES * 8)) - 64'd1);

    logic [2:0]  state_q, state_d;
    logic [15:0] remaining_q, remaining_d;
    logic [15:0] next_idx_q, next_idx_d;
    logic [63:0] rec_data_q, rec_data_d;
    logic [15:0] rec_idx_q, rec_idx_d;
    logic        rec_last_q, rec_last_d;
    logic        rec_valid_q, rec_valid_d;
    logic        rd;
    logic [3:0]  width;
    logic [15:0] hdr_count;

    // Header bytes arrive oldest-first, so the count is already little-endian in [15:0].
    assign hdr_count = bus.buf_r_data[15:0];

    // Next-state, read request and output-register updates.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        next_idx_d  = next_idx_q;
        rec_data_d  = rec_data_q;
        rec_idx_d   = rec_idx_q;
        rec_last_d  = rec_last_q;
        rec_valid_d = rec_valid_q;
        rd          = 1'b0;
        width       = RecWidth;
        case (state_q)
            StIdle: begin
                if (bus.en) state_d = StHdr;
            end
            StHdr: begin
                width = 4'd2;
                rd    = !bus.buf_r_empty;
                if (rd) begin
                    if (hdr_count == 16'd0) begin
                        state_d = StDone;
                    end else begin
                        remaining_d = hdr_count;
                        next_idx_d  = 16'd0;
                        state_d     = StRec;
                    end
                end
            end
            StRec: begin
                // A new record may overwrite the register only once the old one is gone.
                rd = !bus.buf_r_empty && (!rec_valid_q || bus.rec_ready);
                if (rd) begin
                    rec_data_d  = bus.buf_r_data & RecMask;
                    rec_idx_d   = next_idx_q;
                    next_idx_d  = next_idx_q + 16'd1;
                    rec_last_d  = (remaining_q == 16'd1);
                    rec_valid_d = 1'b1;
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) state_d = StDrain;
                end else if (rec_valid_q && bus.rec_ready) begin
                    rec_valid_d = 1'b0;
                end
            end
            StDrain: begin
                if (!rec_valid_q || bus.rec_ready) begin
                    rec_valid_d = 1'b0;
                    state_d     = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Reset must not consume buffer bytes even if the FSM was mid-frame.
        if (rst) rd = 1'b0;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            remaining_q <= 16'd0;
            next_idx_q  <= 16'd0;
            rec_data_q  <= 64'd0;
            rec_idx_q   <= 16'd0;
            rec_last_q  <= 1'b0;
            rec_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            next_idx_q  <= next_idx_d;
            rec_data_q  <= rec_data_d;
            rec_idx_q   <= rec_idx_d;
            rec_last_q  <= rec_last_d;
            rec_valid_q <= rec_valid_d;
        end
    end

    assign bus.buf_r_ready      = rd;
    assign bus.buf_r_data_width = width;
    assign bus.rec_data         = rec_data_q;
    assign bus.rec_idx          = rec_idx_q;
    assign bus.rec_last         = rec_last_q;
    assign bus.rec_valid        = rec_valid_q;
    assign bus.frame_done       = (state_q == StDone);
    assign bus.busy             = (state_q != StIdle);

endmodule

// File: tb/tb_dma_frame_unpacker.sv
// Scoreboard bench for dma_frame_unpacker: a ring-buffer byte model feeds the DUT,
// expected records are queued when a frame is written, and a negedge monitor
// checks every record transfer and the buffer/handshake rules.
module tb_dma_frame_unpacker;

    localparam int unsigned RB = 4;

    typedef struct {
        logic [63:0] data;
        logic [15:0] idx;
        logic        last;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dma_frame_unpacker_if bus ();
    dma_frame_unpacker_if bus3 ();

    dma_frame_unpacker #(.REC_BYTES(RB), .DEBUG(0)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    dma_frame_unpacker #(.REC_BYTES(3), .DEBUG(0)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

    int vectors = 0;
    int errors  = 0;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- byte buffer model (main DUT) ----------------
    logic [7:0] mem [8192];
    int  wr_ptr = 0;
    int  rd_ptr = 0;
    int  reads  = 0;
    bit  stall  = 1'b0;
    bit  flush  = 1'b0;

    always_comb begin
        bus.buf_r_empty = stall || ((wr_ptr - rd_ptr) < int'(bus.buf_r_data_width));
        for (int i = 0; i < 8; i++) bus.buf_r_data[i*8 +: 8] = mem[13'(rd_ptr + i)];
    end

    always @(posedge clk) begin
        if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (bus.buf_r_ready) begin
            rd_ptr <= rd_ptr + int'(bus.buf_r_data_width);
            reads  <= reads + 1;
        end
    end

    // ---------------- byte buffer model (REC_BYTES=3 DUT) ----------------
    logic [7:0] mem3 [16];
    int rd3 = 0;

    always_comb begin
        bus3.buf_r_empty = (10 - rd3) < int'(bus3.buf_r_data_width);
        for (int i = 0; i < 8; i++) bus3.buf_r_data[i*8 +: 8] = mem3[4'(rd3 + i)];
    end

    always @(posedge clk) begin
        if (bus3.buf_r_ready) rd3 <= rd3 + int'(bus3.buf_r_data_width);
    end

    // ---------------- input driver: rec_ready and buffer stalls ----------------
    bit rand_ready = 1'b0;
    bit rand_stall = 1'b0;
    bit rdy_low    = 1'b0;
    int bp_idx     = -1;
    int bp_left    = 0;
    int stall_left = 0;

    initial begin
        bus.rec_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_left > 0 && bus.rec_valid && int'(bus.rec_idx) == bp_idx) begin
                bus.rec_ready = 1'b0;
                bp_left--;
            end else if (rdy_low) begin
                bus.rec_ready = 1'b0;
            end else begin
                bus.rec_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (stall_left > 0) begin
                stall = 1'b1;
                stall_left--;
            end else begin
                stall = rand_stall ? ($urandom_range(0, 4) == 0) : 1'b0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    rec_t        exp_q [$];
    int          done_cnt = 0;
    logic        held = 1'b0;
    logic [63:0] held_data;
    logic [15:0] held_idx;
    logic        held_last;

    always @(negedge clk) begin : monitor
        rec_t e;
        if (rst) begin
            held = 1'b0;
        end else begin
            if (bus.buf_r_ready) check_eq("read_while_empty", 64'(bus.buf_r_empty), 64'd0);
            if (held) begin
                check_eq("hold_valid", 64'(bus.rec_valid), 64'd1);
                check_eq("hold_data", bus.rec_data, held_data);
                check_eq("hold_idx", 64'(bus.rec_idx), 64'(held_idx));
                check_eq("hold_last", 64'(bus.rec_last), 64'(held_last));
            end
            if (bus.rec_valid && !bus.rec_ready)
                check_eq("read_under_backpressure", 64'(bus.buf_r_ready), 64'd0);
            if (bus.rec_valid && bus.rec_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_record_idx", 64'(bus.rec_idx), 64'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("rec_data", bus.rec_data, e.data);
                    check_eq("rec_idx", 64'(bus.rec_idx), 64'(e.idx));
                    check_eq("rec_last", 64'(bus.rec_last), 64'(e.last));
                end
            end
            held      = bus.rec_valid && !bus.rec_ready;
            held_data = bus.rec_data;
            held_idx  = bus.rec_idx;
            held_last = bus.rec_last;
            if (bus.frame_done) done_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    logic [63:0] given [$];
    int reads0     = 0;
    int frames_exp = 0;

    task automatic push_byte(input logic [7:0] b);
        mem[13'(wr_ptr)] = b;
        wr_ptr++;
    endtask

    // Writes a frame into the buffer, queues its expected records, then launches it.
    task automatic start_frame(input int cnt);
        logic [63:0] rec;
        logic [7:0]  b;
        int          n;
        reads0 = reads;
        push_byte(8'(cnt));
        push_byte(8'(cnt >> 8));
        for (int k = 0; k < cnt; k++) begin
            rec = 64'd0;
            for (int j = 0; j < int'(RB); j++) begin
                b = (k < given.size()) ? 8'(given[k] >> (j * 8)) : 8'($urandom);
                push_byte(b);
                rec[j*8 +: 8] = b;
            end
            exp_q.push_back('{rec, 16'(k), (k == cnt - 1)});
        end
        given.delete();
        @(negedge clk);
        bus.en = 1'b1;
        n = 0;
        while (!bus.busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("frame_started", 64'(bus.busy), 64'd1);
        bus.en = 1'b0;
    endtask

    task automatic finish_frame(input int cnt);
        int n = 0;
        while (!bus.frame_done && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check_eq("frame_done_seen", 64'(bus.frame_done), 64'd1);
        check_eq("records_outstanding", 64'(exp_q.size()), 64'd0);
        check_eq("bytes_consumed", 64'(rd_ptr), 64'(wr_ptr));
        check_eq("read_count", 64'(reads - reads0), 64'(cnt + 1));
        frames_exp++;
        @(negedge clk);
        check_eq("done_pulse_len", 64'(bus.frame_done), 64'd0);
        check_eq("idle_after_done", 64'(bus.busy), 64'd0);
    endtask

    task automatic wait_xfer(input int idx);
        int n = 0;
        while (!(bus.rec_valid && bus.rec_ready && int'(bus.rec_idx) == idx) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq("xfer_seen", 64'(n < 500), 64'd1);
    endtask

    initial begin
        logic [63:0] word;
        int          n;
        bus.en  = 1'b0;
        bus3.en = 1'b0;
        bus3.rec_ready = 1'b1;
        word = 64'hDEAD_BEEF_CAFE_F00D;
        for (int i = 0; i < 16; i++) mem3[i] = 8'h00;
        mem3[0] = 8'h01;
        for (int i = 0; i < 8; i++) mem3[4'(2 + i)] = word[i*8 +: 8];

        repeat (3) @(negedge clk);
        check_eq("rst_rec_valid", 64'(bus.rec_valid), 64'd0);
        check_eq("rst_rec_data", bus.rec_data, 64'd0);
        check_eq("rst_rec_idx", 64'(bus.rec_idx), 64'd0);
        check_eq("rst_rec_last", 64'(bus.rec_last), 64'd0);
        check_eq("rst_frame_done", 64'(bus.frame_done), 64'd0);
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_buf_r_ready", 64'(bus.buf_r_ready), 64'd0);
        rst = 1'b0;

        // Three known records with the sink always ready.
        given.push_back(64'h1122_3344);
        given.push_back(64'h5566_7788);
        given.push_back(64'h99AA_BBCC);
        start_frame(3);
        wait_xfer(2);
        @(negedge clk);
        check_eq("done_after_last_xfer", 64'(bus.frame_done), 64'd1);
        finish_frame(3);

        // Empty frame: only the header is read.
        start_frame(0);
        finish_frame(0);

        // Backpressure on record 1 for five cycles.
        bp_idx  = 1;
        bp_left = 5;
        start_frame(3);
        wait_xfer(1);
        check_eq("bp_cycles_used", 64'(bp_left), 64'd0);
        @(negedge clk);
        check_eq("rec2_valid_next", 64'(bus.rec_valid), 64'd1);
        check_eq("rec2_idx_next", 64'(bus.rec_idx), 64'd2);
        finish_frame(3);
        bp_idx = -1;

        // Buffer underflow between records.
        start_frame(4);
        wait_xfer(0);
        stall_left = 4;
        finish_frame(4);

        // Three-byte records are masked to 24 bits.
        @(negedge clk);
        bus3.en = 1'b1;
        n = 0;
        while (!bus3.rec_valid && n < 50) begin
            @(negedge clk);
            if (bus3.busy) bus3.en = 1'b0;
            n++;
        end
        bus3.en = 1'b0;
        check_eq("rb3_valid", 64'(bus3.rec_valid), 64'd1);
        check_eq("rb3_data", bus3.rec_data, 64'h0000_0000_00FE_F00D);
        check_eq("rb3_idx", 64'(bus3.rec_idx), 64'd0);
        check_eq("rb3_last", 64'(bus3.rec_last), 64'd1);

        // Randomized frames with random backpressure and buffer stalls.
        rand_ready = 1'b1;
        rand_stall = 1'b1;
        for (int f = 0; f < 16; f++) begin
            n = $urandom_range(0, 10);
            start_frame(n);
            finish_frame(n);
        end
        rand_ready = 1'b0;
        rand_stall = 1'b0;

        // Reset in the middle of a frame while a record is held.
        rdy_low = 1'b1;
        start_frame(6);
        n = 0;
        while (!bus.rec_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("pre_reset_valid", 64'(bus.rec_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_rec_valid", 64'(bus.rec_valid), 64'd0);
        check_eq("mid_rst_rec_data", bus.rec_data, 64'd0);
        check_eq("mid_rst_rec_idx", 64'(bus.rec_idx), 64'd0);
        check_eq("mid_rst_rec_last", 64'(bus.rec_last), 64'd0);
        check_eq("mid_rst_busy", 64'(bus.busy), 64'd0);
        check_eq("mid_rst_buf_r_ready", 64'(bus.buf_r_ready), 64'd0);
        exp_q.delete();
        flush = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        flush   = 1'b0;
        rdy_low = 1'b0;
        start_frame(5);
        finish_frame(5);

        check_eq("frame_done_count", 64'(done_cnt), 64'(frames_exp));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/dma_frame_unpacker.md
Name: dma_frame_unpacker

Overview:
- Downstream consumer of the DMA byte buffer.
- Pulls a little-endian byte stream out of the buffer's variable-width read port and parses it into frames: a 16-bit record count followed by that many fixed-width records.
- Presents each record to the core-side loader over a valid/ready handshake and pulses a completion strobe per frame.
- Sits between the DMA input buffer and the core/neuron-parameter loaders.

Parameters:
- REC_BYTES, 4, bytes per record; legal range 1..8.
- DEBUG, 1, non-zero enables $display logging of header and record events.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  high allows a new frame to start from IDLE.
- buf_r_data  in  64  buffer read data; byte 0 (bits 7:0) is the oldest byte.
- buf_r_empty  in  1  high if the buffer holds fewer than buf_r_data_width bytes.
- buf_r_data_width  out  4  bytes requested from the buffer.
- buf_r_ready  out  1  consume buf_r_data_width bytes this cycle.
- rec_data  out  64  record payload; bits above REC_BYTES*8 are zero.
- rec_idx  out  16  index of the presented record within its frame, starting at 0.
- rec_last  out  1  high with the final record of a frame.
- rec_valid  out  1  record available.
- rec_ready  in  1  sink accepts the record.
- frame_done  out  1  one-cycle pulse when a frame completes.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: state IDLE; buf_r_ready=0; rec_valid=0; rec_data=0; rec_idx=0; rec_last=0; frame_done=0; busy=0; internal remaining-count=0. Reset wins over all other events in the same cycle. Reset mid-frame discards any held record; the buffer is not touched.
- buf_r_data_width is 2 in HDR and REC_BYTES in every other state.
- buf_r_ready is combinational. It is only ever asserted while !buf_r_empty. A read means buf_r_ready=1; bytes are consumed on that clock edge.

States:
- IDLE: if en, go to HDR next cycle. No reads.
- HDR: buf_r_ready = !buf_r_empty. On a read, count = {buf_r_data[15:8], buf_r_data[7:0]}.
  - count==0: go to DONE.
  - otherwise: remaining<=count, next_idx<=0, go to REC.
- REC: read permitted when !buf_r_empty && (!rec_valid || rec_ready). Single-entry output register, so full throughput of one record per cycle. On a read:
  - rec_data <= buf_r_data masked to REC_BYTES*8 bits.
  - rec_idx <= next_idx; next_idx++.
  - rec_last <= (remaining==1).
  - rec_valid <= 1; remaining--.
  - When remaining reaches 0, go to DRAIN.
  - If rec_ready && rec_valid with no new read, rec_valid <= 0.
- DRAIN: no reads. When !rec_valid, or rec_valid && rec_ready, clear rec_valid and go to DONE.
- DONE: frame_done=1 for exactly one cycle, then go to IDLE. A frame restarts no earlier than two cycles after DONE (IDLE then HDR).

Handshake and timing:
- A record is transferred when rec_valid && rec_ready.
- While rec_valid=1 && rec_ready=0, rec_data/rec_idx/rec_last hold stable.
- Latency: record bytes available at buffer -> rec_valid one cycle later.

Boundary conditions:
- Buffer empty mid-frame: stall in the current state with no reads and outputs held.
- count=65535: rec_idx runs 0..65534 with no wrap.
- en dropping mid-frame has no effect; the frame completes.
- DEBUG: log "[RTL][dma_frame_unpacker]" with the header count on the HDR read and the index per record.

Test Plan:
- Header bytes 0x03,0x00, then records 0x11223344, 0x55667788, 0x99AABBCC (REC_BYTES=4), rec_ready=1 -> three records with rec_idx 0,1,2; rec_last only on idx 2; frame_done one cycle after the last transfer; exactly 14 bytes consumed.
- Header 0x00,0x00 -> no rec_valid; frame_done pulses; buf_r_ready asserted only once, with width 2.
- Backpressure: rec_ready held low 5 cycles on record 1 -> rec_data stable; buf_r_ready=0 in REC throughout; record 2 appears the cycle after rec_ready rises.
- Buffer underflow: buf_r_empty=1 for 4 cycles between records -> no buf_r_ready; rec_idx continues correctly afterwards; no duplicate or lost record.
- REC_BYTES=3, buffer word 0xDEADBEEFCAFEF00D -> rec_data=0x0000000000FEF00D.
- rst=1 asserted mid-REC with rec_valid=1 -> next cycle all outputs at reset values; a new frame with en=1 parses correctly.
